spm_prog_loader: RTL
====================

Name: spm_prog_loader

Overview:
Byte-stream program loader that sits on the SRAM side of the RISC_SPM top, in parallel with the processor's memory port.
- Accepts a framed image over a valid/ready byte interface and writes it into Memory_Unit through the same address/data_in/write signals the processor drives.
- Holds the processor in reset (cpu_rst) until the image is loaded and its checksum passes.
- It is the writer for the memory the processor later reads; the top muxes memory inputs by cpu_rst.

Parameters:
word_size, 8, data and stream byte width
addr_size, 8, memory address width (256 locations)
base_addr, 8'h00, first memory address written

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-high
start  input  1  one-cycle pulse, begin a load; honoured only in IDLE, DONE, ERR
in_data  input  word_size  stream byte
in_valid  input  1  in_data valid
in_ready  output  1  loader can accept a byte this cycle
mem_address  output  addr_size  memory address
mem_data_in  output  word_size  data to memory data_in
mem_write  output  1  memory write strobe; memory samples on the clk edge
cpu_rst  output  1  hold processor/controller in reset while high
busy  output  1  high in LEN, DATA, WRITE, CSUM
done  output  1  load completed with good checksum
error  output  1  checksum mismatch
load_count  output  addr_size+1  bytes written so far in the current load

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state=IDLE, in_ready=0, mem_write=0, mem_address=base_addr, mem_data_in=0, cpu_rst=1, busy=0, done=0, error=0, load_count=0, checksum accumulator=0.
- Frame: LEN byte N (0 encodes 256), then N data bytes, then CSUM byte. CSUM equals the sum of the data bytes mod 256; the LEN byte is excluded.
- Handshake: a byte transfers on a clk edge where in_valid && in_ready. in_ready=1 only in LEN, DATA, CSUM. in_data may change freely when not accepted.
- States:
  - IDLE: start -> LEN; clear load_count and accumulator; cpu_rst=1.
  - LEN: on accept, latch N (9-bit, 0 -> 256) -> DATA.
  - DATA: on accept, register byte into mem_data_in, set mem_address = base_addr + load_count (mod 256), add byte to accumulator -> WRITE.
  - WRITE: mem_write=1 for exactly this cycle, in_ready=0. Then load_count++. If load_count+1 == N -> CSUM, else -> DATA.
  - CSUM: on accept, compare byte to accumulator. Equal -> DONE, else -> ERR.
  - DONE: done=1, cpu_rst=0, mem_write=0. Holds until start (-> LEN, cpu_rst=1 the next cycle) or rst.
  - ERR: error=1, cpu_rst stays 1. Holds until start (-> LEN, error cleared) or rst.
- Throughput: one data byte per 2 cycles max. Latency from accepting the last data byte to the mem_write cycle is 1 clk.
- Address wrap: base_addr + index wraps mod 2^addr_size. N=256 with base_addr≠0 overwrites nothing twice (exactly 256 distinct locations).
- start while busy: ignored. start and in_valid in the same cycle in IDLE: only start is acted on; the byte is not accepted (in_ready=0 in IDLE).
- rst mid-load, including during WRITE: next cycle is the reset state, mem_write=0. Already-written memory is not restored. cpu_rst stays 1.
- mem_write is never high outside WRITE. mem_address and mem_data_in are stable throughout WRITE.

Decomposition:
- Shared package spm_pkg: word_size/addr_size constants and state encoding localparams (IDLE, LEN, DATA, WRITE, CSUM, DONE, ERR; 3-bit).
- Single module. Checksum accumulator and index counter are inline; no sub-module is warranted.
- Top-level mux of memory inputs (processor vs loader, selected by cpu_rst) belongs to the RISC_SPM top, not this block.

Test Plan:
- Basic load: base_addr=0, start, stream 03,11,22,33,66 with in_valid held -> writes 11@00, 22@01, 33@02 on three single-cycle mem_write pulses; done=1, cpu_rst=0, load_count=3.
- Bad checksum: stream 02,AA,01,00 -> two writes, then error=1, done=0, cpu_rst=1. A later start plus stream 01,5A,5A -> done=1, error=0.
- Length 0 / wrap: base_addr=8'hF0, LEN=00, 256 bytes of value i, CSUM=80 -> last write is FF@EF, load_count=256, done=1.
- Backpressure gaps: random in_valid idle cycles between bytes -> no spurious mem_write; addresses strictly sequential; result identical to the basic load.
- Reset mid-operation: assert rst during the WRITE of byte 2 of 4 -> next cycle mem_write=0, state IDLE, cpu_rst=1, load_count=0, busy=0.
- start during load: pulse start while in DATA -> ignored, load_count continues, frame completes normally.

Source files
------------

// File: rtl/spm_pkg.sv
// Shared constants and state encoding for the SPM program loader.
package spm_pkg;

  localparam int default_word_size = 8;
  localparam int default_addr_size = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LEN   = 3'd1,
    DATA  = 3'd2,
    WRITE = 3'd3,
    CSUM  = 3'd4,
    DONE  = 3'd5,
    ERR   = 3'd6
  } state_t;

endpackage

// File: rtl/spm_prog_loader.sv
// Framed byte-stream loader: LEN, N data bytes, CSUM. Writes the image into
// SPM memory and holds the processor in reset until the checksum passes.
module spm_prog_loader
  import spm_pkg::*;
#(
  parameter int word_size = default_word_size,
  parameter int addr_size = default_addr_size,
  parameter logic [addr_size-1:0] base_addr = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [word_size-1:0] in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [addr_size-1:0] mem_address,
  output logic [word_size-1:0] mem_data_in,
  output logic                 mem_write,
  output logic                 cpu_rst,
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  output logic [addr_size:0]   load_count
);

  localparam logic [addr_size:0] full_len = {1'b1, {addr_size{1'b0}}};

  state_t               state_reg, state_next;
  logic [addr_size:0]   len_reg, len_next;
  logic [addr_size:0]   count_reg, count_next;
  logic [addr_size:0]   count_inc;
  logic [word_size-1:0] acc_reg, acc_next;
  logic [word_size-1:0] data_reg, data_next;
  logic [addr_size-1:0] addr_reg, addr_next;
  logic                 accept;

  // Status outputs decode straight from the state register, so reset and
  // every transition are reflected in the same cycle the state changes.
  assign in_ready    = (state_reg == LEN) || (state_reg == DATA) || (state_reg == CSUM);
  assign accept      = in_valid && in_ready;
  assign mem_write   = (state_reg == WRITE);
  assign busy        = (state_reg == LEN) || (state_reg == DATA) ||
                       (state_reg == WRITE) || (state_reg == CSUM);
  assign done        = (state_reg == DONE);
  assign error       = (state_reg == ERR);
  assign cpu_rst     = (state_reg != DONE);
  assign mem_address = addr_reg;
  assign mem_data_in = data_reg;
  assign load_count  = count_reg;
  assign count_inc   = count_reg + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      len_reg   <= '0;
      count_reg <= '0;
      acc_reg   <= '0;
      data_reg  <= '0;
      addr_reg  <= base_addr;
    end else begin
      state_reg <= state_next;
      len_reg   <= len_next;
      count_reg <= count_next;
      acc_reg   <= acc_next;
      data_reg  <= data_next;
      addr_reg  <= addr_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    len_next   = len_reg;
    count_next = count_reg;
    acc_next   = acc_reg;
    data_next  = data_reg;
    addr_next  = addr_reg;
    case (state_reg)
      IDLE, DONE, ERR: begin
        if (start) begin
          state_next = LEN;
          count_next = '0;
          acc_next   = '0;
        end
      end
      LEN: begin
        if (accept) begin
          // A zero length byte stands for a full memory image.
          len_next   = (in_data == '0) ? full_len : (addr_size+1)'(in_data);
          state_next = DATA;
        end
      end
      DATA: begin
        if (accept) begin
          data_next  = in_data;
          addr_next  = base_addr + count_reg[addr_size-1:0];
          acc_next   = acc_reg + in_data;
          state_next = WRITE;
        end
      end
      WRITE: begin
        count_next = count_inc;
        state_next = (count_inc == len_reg) ? CSUM : DATA;
      end
      CSUM: begin
        if (accept) begin
          state_next = (in_data == acc_reg) ? DONE : ERR;
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule
